// File: rtl/pc_fetch_unit.sv
// Program counter and fetch sequencer: sequential advance with valid/ready backpressure,
// prioritised trap/JALR/branch redirects, one-cycle redirect bubble and misalign error state.
module pc_fetch_unit #(
  parameter int unsigned      XLEN         = 32,
  parameter logic [XLEN-1:0]  RESET_VECTOR = XLEN'(32'h0000_0000),
  parameter logic [XLEN-1:0]  TRAP_VECTOR  = XLEN'(32'h0000_0100),
  parameter int unsigned      PC_STEP      = 4,
  parameter logic [1:0]       ALIGN_MASK   = 2'b11
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [XLEN-1:0] pc_imm,
  input  logic            Branch,
  input  logic            jalr,
  input  logic [XLEN-1:0] jalr_base,
  input  logic            trap_req,
  input  logic            stall,
  input  logic            pc_ready,
  output logic [XLEN-1:0] pc,
  output logic            pc_valid,
  output logic [XLEN-1:0] epc,
  output logic            misalign_err
);

  typedef enum logic [1:0] {
    S_BOOT   = 2'd0,
    S_RUN    = 2'd1,
    S_BUBBLE = 2'd2,
    S_ERR    = 2'd3
  } state_e;

  state_e          state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] epc_q, epc_d;
  logic            valid_q, valid_d;
  logic            err_q, err_d;

  logic [XLEN-1:0] jalr_sum;
  logic [XLEN-1:0] target;
  logic            misalign;
  logic            redirect;

  // Redirect target selection; JALR wins over branch when both are present.
  always_comb begin
    jalr_sum = jalr_base + pc_imm;
    target   = jalr ? {jalr_sum[XLEN-1:1], 1'b0} : (pc_q + pc_imm);
    misalign = |(target[1:0] & ALIGN_MASK);
    redirect = (jalr || Branch) && ((state_q == S_RUN) || (state_q == S_BUBBLE));
  end

  // State and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_BOOT;
      pc_q    <= RESET_VECTOR;
      epc_q   <= '0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      epc_q   <= epc_d;
      valid_q <= valid_d;
      err_q   <= err_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_BOOT:           state_d = trap_req ? S_BUBBLE : S_RUN;
      S_RUN, S_BUBBLE: begin
        if (trap_req)      state_d = S_BUBBLE;
        else if (redirect) state_d = misalign ? S_ERR : S_BUBBLE;
        else               state_d = S_RUN;
      end
      S_ERR:            state_d = trap_req ? S_BUBBLE : S_ERR;
      default:          state_d = S_BOOT;
    endcase
  end

  // Next values of the registered outputs.
  always_comb begin
    pc_d    = pc_q;
    epc_d   = epc_q;
    valid_d = (state_d == S_RUN);
    err_d   = (state_d == S_ERR);
    if (trap_req) begin
      pc_d  = TRAP_VECTOR;
      epc_d = pc_q;
    end else if (redirect) begin
      pc_d = target;
    end else if ((state_q == S_RUN) && pc_ready && !stall) begin
      pc_d = pc_q + XLEN'(PC_STEP);
    end
  end

  assign pc           = pc_q;
  assign pc_valid     = valid_q;
  assign epc          = epc_q;
  assign misalign_err = err_q;

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Scoreboard bench for pc_fetch_unit: driver pushes model expectations, monitor pops and compares.
module tb_pc_fetch_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] pc_imm = '0;
  logic        Branch = 1'b0;
  logic        jalr = 1'b0;
  logic [31:0] jalr_base = '0;
  logic        trap_req = 1'b0;
  logic        stall = 1'b0;
  logic        pc_ready = 1'b0;
  logic [31:0] pc;
  logic        pc_valid;
  logic [31:0] epc;
  logic        misalign_err;

  pc_fetch_unit dut (
    .clk(clk), .rst(rst), .pc_imm(pc_imm), .Branch(Branch), .jalr(jalr),
    .jalr_base(jalr_base), .trap_req(trap_req), .stall(stall), .pc_ready(pc_ready),
    .pc(pc), .pc_valid(pc_valid), .epc(epc), .misalign_err(misalign_err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] pc;
    logic        valid;
    logic [31:0] epc;
    logic        err;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  // Reference model: plain description of where the fetch address goes next.
  logic [31:0] m_pc = '0;
  logic [31:0] m_epc = '0;
  bit          m_valid = 1'b0;
  bit          m_err = 1'b0;
  bit          m_boot = 1'b1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, req, $time);
    end
  endtask

  // Monitor: compare every cycle's outputs against the next expectation.
  always begin
    @(posedge clk);
    #1;
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      chk("pc", pc, e.pc);
      chk("pc_valid", 32'(pc_valid), 32'(e.valid));
      chk("epc", epc, e.epc);
      chk("misalign_err", 32'(misalign_err), 32'(e.err));
    end
  end

  task automatic cyc(input bit r, input bit t, input bit j, input bit b,
                     input bit s, input bit rdy,
                     input logic [31:0] imm, input logic [31:0] base);
    logic [31:0] tgt;
    exp_t e;
    rst = r; trap_req = t; jalr = j; Branch = b; stall = s; pc_ready = rdy;
    pc_imm = imm; jalr_base = base;
    if (r) begin
      m_pc = 32'h0; m_epc = 32'h0; m_valid = 0; m_err = 0; m_boot = 1;
    end else if (t) begin
      m_epc = m_pc; m_pc = 32'h100; m_valid = 0; m_err = 0; m_boot = 0;
    end else if (m_boot) begin
      m_boot = 0; m_valid = 1;
    end else if (m_err) begin
      m_valid = 0;
    end else if (j || b) begin
      tgt = j ? ((base + imm) & 32'hFFFF_FFFE) : (m_pc + imm);
      m_pc = tgt;
      m_valid = 0;
      m_err = (tgt[1:0] != 2'b00);
    end else if (m_valid) begin
      if (rdy && !s) m_pc = m_pc + 32'd4;
    end else begin
      m_valid = 1;
    end
    e.pc = m_pc; e.valid = m_valid; e.epc = m_epc; e.err = m_err;
    exp_q.push_back(e);
    @(negedge clk);
  endtask

  task automatic idle(input int n, input bit rdy);
    for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, 0, rdy, 32'h0, 32'h0);
  endtask

  initial begin
    // Reset, boot and sequential fetch
    cyc(1, 0, 0, 0, 0, 1, 0, 0);
    cyc(1, 0, 0, 0, 0, 1, 0, 0);
    idle(3, 1);
    // Forward then backward branch
    cyc(0, 0, 0, 1, 0, 1, 32'd8, 0);
    idle(2, 1);
    cyc(0, 0, 0, 1, 0, 1, 32'hFFFF_FFF8, 0);
    idle(1, 1);
    // Stall and backpressure, branch during stall
    cyc(0, 0, 0, 0, 1, 1, 0, 0);
    cyc(0, 0, 0, 0, 1, 1, 0, 0);
    cyc(0, 0, 0, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 1, 1, 0, 32'd16, 0);
    idle(2, 1);
    // JALR over branch, then trap over both
    cyc(0, 0, 1, 1, 0, 1, 32'd3, 32'h1001);
    idle(2, 1);
    cyc(0, 1, 1, 1, 0, 1, 32'd3, 32'h1001);
    idle(4, 1);
    // Misaligned branch into ERR, held, then trap recovery
    cyc(0, 0, 0, 1, 0, 1, 32'd6, 0);
    cyc(0, 0, 0, 1, 0, 1, 32'd8, 0);
    idle(3, 1);
    cyc(0, 1, 0, 0, 0, 1, 0, 0);
    idle(2, 1);
    // Address wrap and reset during bubble
    cyc(0, 0, 1, 0, 0, 1, 32'd8, 32'hFFFF_FFF0);
    idle(4, 1);
    cyc(0, 0, 0, 1, 0, 1, 32'd32, 0);
    cyc(1, 0, 0, 0, 0, 1, 0, 0);
    idle(3, 1);
    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      logic [31:0] imm, base;
      imm = 32'($signed(32'($urandom_range(0, 31)) - 32'sd16) * 4);
      if ($urandom_range(0, 7) == 0) imm = imm + 32'($urandom_range(1, 3));
      base = $urandom() & 32'hFFFF_FFFC;
      if ($urandom_range(0, 3) == 0) base = base | 32'h1;
      if ($urandom_range(0, 5) == 0) base = base | 32'h2;
      cyc($urandom_range(0, 99) == 0, $urandom_range(0, 24) == 0,
          $urandom_range(0, 11) == 0, $urandom_range(0, 7) == 0,
          $urandom_range(0, 3) == 0, $urandom_range(0, 3) != 0, imm, base);
    end
    idle(2, 1);
    repeat (3) @(posedge clk);
    #2;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending expected 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
